sr_bank_scheduler: RTL and testbench

Shares a WIDTH-bit bank of SR flip-flops among NREQ requesters. Each requester presents set/clear bit masks under a req/gnt handshake. The block arbitrates round-robin and drives the bank's S and R vectors for exactly one cycle per command. It never drives S=R=1 on any bit, keeps a shadow of the expected bank state, and checks the bank's q feedback against that shadow after every write.

---
 rtl/sr_bank_scheduler.sv | 136 +++++++++++++
 tb/tb_sr_bank_scheduler.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_bank_scheduler.sv
// Round-robin scheduler sharing one SR flip-flop bank among NREQ requesters.
// Drives S/R for one cycle per command, tracks a shadow copy and checks bank_q against it.
module sr_bank_scheduler #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_set,
    input  logic [NREQ*WIDTH-1:0] req_clr,
    input  logic [WIDTH-1:0]      bank_q,
    output logic [WIDTH-1:0]      sr_s,
    output logic [WIDTH-1:0]      sr_r,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       err,
    output logic                  mismatch,
    output logic [WIDTH-1:0]      shadow,
    output logic                  busy
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_DRIVE,
        ST_CHECK
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   sel_q, sel_d;
    logic [WIDTH-1:0]   set_eff_q, set_eff_d;
    logic [WIDTH-1:0]   clr_eff_q, clr_eff_d;
    logic [WIDTH-1:0]   shadow_q, shadow_d;
    logic               ovl_q, ovl_d;

    logic [WIDTH-1:0]   set_arr [NREQ];
    logic [WIDTH-1:0]   clr_arr [NREQ];
    logic               pick_found;
    logic [PTR_W-1:0]   pick_idx;
    logic [PTR_W-1:0]   cand;

    // Unpack the flat mask buses into per-requester words.
    always_comb begin
        for (int i = 0; i < int'(NREQ); i++) begin
            set_arr[i] = req_set[i*WIDTH +: WIDTH];
            clr_arr[i] = req_clr[i*WIDTH +: WIDTH];
        end
    end

    // First asserted requester at or after ptr, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            cand = PTR_W'((int'(ptr_q) + k) % int'(NREQ));
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        set_eff_d = set_eff_q;
        clr_eff_d = clr_eff_q;
        shadow_d  = shadow_q;
        ovl_d     = ovl_q;
        sr_s      = '0;
        sr_r      = '0;
        gnt       = '0;
        err       = '0;
        mismatch  = 1'b0;
        busy      = 1'b1;
        shadow    = shadow_q;

        case (state_q)
            ST_INIT: begin
                sr_r    = '1;
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                busy = 1'b0;
                if (pick_found) begin
                    sel_d     = pick_idx;
                    // Clear wins where a command both sets and clears a bit.
                    set_eff_d = set_arr[pick_idx] & ~clr_arr[pick_idx];
                    clr_eff_d = clr_arr[pick_idx];
                    ovl_d     = |(set_arr[pick_idx] & clr_arr[pick_idx]);
                    state_d   = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                sr_s     = set_eff_q;
                sr_r     = clr_eff_q;
                shadow_d = (shadow_q | set_eff_q) & ~clr_eff_q;
                state_d  = ST_CHECK;
            end
            ST_CHECK: begin
                gnt[sel_q] = 1'b1;
                err[sel_q] = ovl_q;
                mismatch   = (bank_q != shadow_q);
                ptr_d      = (sel_q == PTR_W'(NREQ - 1)) ? '0 : sel_q + 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= ST_INIT;
            ptr_q     <= '0;
            sel_q     <= '0;
            set_eff_q <= '0;
            clr_eff_q <= '0;
            shadow_q  <= '0;
            ovl_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            set_eff_q <= set_eff_d;
            clr_eff_q <= clr_eff_d;
            shadow_q  <= shadow_d;
            ovl_q     <= ovl_d;
        end
    end

endmodule

// File: tb/tb_sr_bank_scheduler.sv
// Bench for sr_bank_scheduler: SR bank model plus a command-level reference model,
// checked every cycle, with directed scenarios pinned by literal expectations.
module tb_sr_bank_scheduler;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int M_INIT  = 0;
    localparam int M_IDLE  = 1;
    localparam int M_DRIVE = 2;
    localparam int M_CHECK = 3;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic [NREQ-1:0]       req;
    logic [WIDTH-1:0]      set_a [NREQ];
    logic [WIDTH-1:0]      clr_a [NREQ];
    logic [NREQ*WIDTH-1:0] req_set, req_clr;
    logic [WIDTH-1:0]      bank, bank_q;
    logic                  force_zero;
    logic [WIDTH-1:0]      sr_s, sr_r, shadow;
    logic [NREQ-1:0]       gnt, err;
    logic                  mismatch, busy;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    sr_bank_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk(clk), .rstn(rstn), .req(req), .req_set(req_set), .req_clr(req_clr),
        .bank_q(bank_q), .sr_s(sr_s), .sr_r(sr_r), .gnt(gnt), .err(err),
        .mismatch(mismatch), .shadow(shadow), .busy(busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_set = {set_a[3], set_a[2], set_a[1], set_a[0]};
        req_clr = {clr_a[3], clr_a[2], clr_a[1], clr_a[0]};
    end

    // SR flip-flop bank driven by the scheduler; force_zero fakes a stuck bank.
    always @(posedge clk) bank <= (bank & ~sr_r) | sr_s;
    assign bank_q = force_zero ? '0 : bank;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one command at a time, walking init/idle/drive/check phases.
    int               m_st;
    bit               m_valid = 1'b0;
    logic [1:0]       m_ptr, m_sel;
    logic [WIDTH-1:0] m_set, m_clr, m_shadow;
    logic             m_ovl;

    always @(posedge clk) begin
        cyc++;
        if (!rstn) begin
            m_valid  = 1'b1;
            m_st     = M_INIT;
            m_ptr    = 2'd0;
            m_sel    = 2'd0;
            m_set    = '0;
            m_clr    = '0;
            m_ovl    = 1'b0;
            m_shadow = '0;
        end else if (m_valid) begin
            case (m_st)
                M_INIT: m_st = M_IDLE;
                M_IDLE: begin
                    if (req != '0) begin
                        for (int k = 0; k < NREQ; k++) begin
                            logic [1:0] j;
                            j = 2'((int'(m_ptr) + k) % NREQ);
                            if (req[j]) begin
                                m_sel = j;
                                m_set = set_a[j];
                                m_clr = clr_a[j];
                                break;
                            end
                        end
                        m_ovl = (m_set & m_clr) != '0;
                        m_st  = M_DRIVE;
                    end
                end
                M_DRIVE: begin
                    m_shadow = (m_shadow | m_set) & ~m_clr;
                    m_st     = M_CHECK;
                end
                default: begin
                    m_ptr = 2'((int'(m_sel) + 1) % NREQ);
                    m_st  = M_IDLE;
                end
            endcase
        end
    end

    // Per-scenario observations gathered by the compare process.
    int               drv_cnt = 0;
    int               mm_cnt  = 0;
    logic [WIDTH-1:0] last_s, last_r;
    logic [NREQ-1:0]  last_gnt, last_err;
    logic [NREQ-1:0]  gnt_log [$];
    int               gnt_cyc [$];

    always @(negedge clk) begin
        logic [WIDTH-1:0] e_s, e_r;
        logic [NREQ-1:0]  e_g, e_e;
        logic             e_m, e_b;
        if (m_valid) begin
            e_s = '0; e_r = '0; e_g = '0; e_e = '0; e_m = 1'b0; e_b = 1'b1;
            case (m_st)
                M_INIT:  e_r = '1;
                M_IDLE:  e_b = 1'b0;
                M_DRIVE: begin e_s = m_set & ~m_clr; e_r = m_clr; end
                default: begin
                    e_g = 4'(1 << m_sel);
                    e_e = m_ovl ? e_g : '0;
                    e_m = (bank_q !== m_shadow);
                end
            endcase
            check("cycle_outputs", {sr_s, sr_r, gnt, err, mismatch, shadow, busy},
                  {e_s, e_r, e_g, e_e, e_m, m_shadow, e_b});
            check("s_and_r_disjoint", sr_s & sr_r, '0);
            if ((sr_s | sr_r) != '0 && busy && sr_r != '1) begin
                drv_cnt++;
                last_s = sr_s;
                last_r = sr_r;
            end
            if (mismatch) mm_cnt++;
            if (gnt != '0) begin
                gnt_log.push_back(gnt);
                gnt_cyc.push_back(cyc);
                last_gnt = gnt;
                last_err = err;
            end
        end
    end

    task automatic issue(input logic [1:0] i, input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c,
                         input bit scramble);
        bit got;
        drv_cnt  = 0;
        mm_cnt   = 0;
        last_s   = '0;
        last_r   = '0;
        set_a[i] = s;
        clr_a[i] = c;
        req[i]   = 1'b1;
        if (scramble) begin
            @(posedge clk); #2;
            set_a[i] = ~s;
            clr_a[i] = ~c;
        end
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk); #1;
            if (gnt[i]) got = 1'b1;
        end
        check("gnt_arrives", got, 1'b1);
        @(posedge clk); #2;
        req[i] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [NREQ-1:0] exp_g [5];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rstn = 1'b0;
        req = '0;
        force_zero = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            set_a[i] = '0;
            clr_a[i] = '0;
        end

        // Reset and release: INIT holds one cycle, then IDLE.
        repeat (3) @(posedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);
        check("init_sr_r", sr_r, 8'hFF);
        check("init_busy", busy, 1'b1);
        @(negedge clk);
        check("idle_busy", busy, 1'b0);
        check("idle_shadow", shadow, 8'h00);
        check("idle_gnt_err", {gnt, err}, '0);

        // Plain set from requester 0.
        issue(2'd0, 8'h0F, 8'h00, 1'b0);
        check("t_set_drive_cycles", drv_cnt, 1);
        check("t_set_sr_s", last_s, 8'h0F);
        check("t_set_gnt", last_gnt, 4'b0001);
        check("t_set_shadow", shadow, 8'h0F);
        check("t_set_mismatch", mm_cnt, 0);

        // Empty command, masks changed after selection must not matter.
        issue(2'd1, 8'h00, 8'h00, 1'b1);
        check("t_empty_drive_cycles", drv_cnt, 0);
        check("t_empty_gnt", last_gnt, 4'b0010);
        check("t_empty_shadow", shadow, 8'h0F);

        // Overlapping set/clear from requester 2.
        issue(2'd2, 8'hF0, 8'h30, 1'b0);
        check("t_ovl_sr_s", last_s, 8'hC0);
        check("t_ovl_sr_r", last_r, 8'h30);
        check("t_ovl_gnt", last_gnt, 4'b0100);
        check("t_ovl_err", last_err, 4'b0100);
        check("t_ovl_shadow", shadow, 8'hCF);

        // Bank stuck at zero while shadow becomes 0x01.
        force_zero = 1'b1;
        issue(2'd3, 8'h01, 8'hFE, 1'b0);
        force_zero = 1'b0;
        check("t_mm_pulses", mm_cnt, 1);
        check("t_mm_shadow", shadow, 8'h01);

        // Reset during DRIVE abandons the command.
        set_a[1] = 8'hAA;
        clr_a[1] = 8'h00;
        req[1]   = 1'b1;
        base     = gnt_log.size();
        @(posedge clk); #2;
        check("t_rst_in_drive", sr_s, 8'hAA);
        rstn = 1'b0;
        @(posedge clk); #2;
        check("t_rst_sr_r", sr_r, 8'hFF);
        check("t_rst_gnt", gnt, '0);
        check("t_rst_shadow", shadow, 8'h00);
        req[1] = 1'b0;
        @(posedge clk); #2;
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("t_rst_no_gnt", gnt_log.size(), base);

        // All requesters held high: round-robin, one grant per 3 cycles.
        for (int i = 0; i < NREQ; i++) begin
            set_a[i] = 8'(8'h11 << i);
            clr_a[i] = (i == 1) ? 8'h11 : 8'h00;
        end
        base = gnt_log.size();
        req  = '1;
        for (int t = 0; t < 40 && gnt_log.size() < base + 5; t++) @(posedge clk);
        #2 req = '0;
        check("t_rr_count", gnt_log.size() >= base + 5, 1'b1);
        if (gnt_log.size() >= base + 5) begin
            for (int k = 0; k < 5; k++) begin
                check("t_rr_order", gnt_log[base+k], exp_g[k]);
                if (k > 0) check("t_rr_spacing", gnt_cyc[base+k] - gnt_cyc[base+k-1], 3);
            end
        end

        repeat (6) @(posedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
